// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Brief    : Multi-cycle CPU control unit (IF/ID/EXE/MEM/WB FSM + decode).
// Revision : 1.0
// ============================================================================
module mc_ctrl #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       mRD,
    output logic       mWR,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       DBDataSrc,
    output logic       ExtSel,
    output logic [2:0] state
);

    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_SUB  = 6'b000001;
    localparam logic [5:0] c_OP_AND  = 6'b010001;
    localparam logic [5:0] c_OP_OR   = 6'b010010;
    localparam logic [5:0] c_OP_SLT  = 6'b100110;
    localparam logic [5:0] c_OP_SLL  = 6'b011000;
    localparam logic [5:0] c_OP_ADDI = 6'b000010;
    localparam logic [5:0] c_OP_ORI  = 6'b010000;
    localparam logic [5:0] c_OP_SW   = 6'b110000;
    localparam logic [5:0] c_OP_LW   = 6'b110001;
    localparam logic [5:0] c_OP_BEQ  = 6'b110100;
    localparam logic [5:0] c_OP_J    = 6'b111000;
    localparam logic [5:0] c_OP_JAL  = 6'b111010;
    localparam logic [5:0] c_OP_JR   = 6'b111001;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_t;

    state_t     r_state;
    logic       r_halt;

    logic       w_is_halt;
    logic       w_is_jump;
    logic       w_is_jal;
    logic       w_is_jr;
    logic       w_is_beq;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_itype;
    logic [2:0] w_aluop;

    assign w_is_halt  = (op == HALT_OP);
    assign w_is_jal   = (op == c_OP_JAL);
    assign w_is_jr    = (op == c_OP_JR);
    assign w_is_jump  = (op == c_OP_J) || w_is_jal || w_is_jr;
    assign w_is_beq   = (op == c_OP_BEQ);
    assign w_is_lw    = (op == c_OP_LW);
    assign w_is_sw    = (op == c_OP_SW);
    assign w_is_itype = (op == c_OP_ADDI) || (op == c_OP_ORI);

    // Unlisted opcodes fall through to add.
    always_comb begin
        w_aluop = 3'b000;
        case (op)
            c_OP_ADD, c_OP_ADDI, c_OP_LW, c_OP_SW: w_aluop = 3'b000;
            c_OP_SUB, c_OP_BEQ:                    w_aluop = 3'b001;
            c_OP_AND:                              w_aluop = 3'b010;
            c_OP_OR, c_OP_ORI:                     w_aluop = 3'b011;
            c_OP_SLT:                              w_aluop = 3'b100;
            c_OP_SLL:                              w_aluop = 3'b101;
            default:                               w_aluop = 3'b000;
        endcase
    end

    // HALT keeps the ID encoding; r_halt marks it and freezes the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IF;
            r_halt  <= 1'b0;
        end else if (!r_halt) begin
            case (r_state)
                ST_IF: r_state <= ST_ID;
                ST_ID: begin
                    if (w_is_halt)                r_halt  <= 1'b1;
                    else if (w_is_jump)           r_state <= ST_IF;
                    else if (w_is_beq)            r_state <= ST_EXE_BR;
                    else if (w_is_lw || w_is_sw)  r_state <= ST_EXE_LS;
                    else                          r_state <= ST_EXE_AL;
                end
                ST_EXE_AL: r_state <= ST_WB_AL;
                ST_EXE_BR: r_state <= ST_IF;
                ST_EXE_LS: r_state <= ST_MEM;
                ST_MEM:    r_state <= w_is_lw ? ST_WB_LD : ST_IF;
                ST_WB_AL:  r_state <= ST_IF;
                ST_WB_LD:  r_state <= ST_IF;
                default:   r_state <= ST_IF;
            endcase
        end
    end

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        PCSrc     = 2'b00;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        ExtSel    = 1'b0;
        if (!rst) begin
            if (r_state != ST_IF) begin
                ALUOp   = w_aluop;
                ALUSrcA = (op == c_OP_SLL);
                ALUSrcB = w_is_itype || w_is_lw || w_is_sw;
                ExtSel  = (op != c_OP_ORI);
            end
            case (r_state)
                ST_IF: IRWre = 1'b1;
                ST_ID: begin
                    if (!r_halt && w_is_jump) begin
                        PCWre  = 1'b1;
                        PCSrc  = w_is_jr ? 2'b10 : 2'b11;
                        RegWre = w_is_jal;
                    end
                end
                ST_EXE_BR: begin
                    ALUOp = 3'b001;
                    PCWre = 1'b1;
                    PCSrc = zero ? 2'b01 : 2'b00;
                end
                ST_MEM: begin
                    if (w_is_sw) begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end else if (w_is_lw) begin
                        mRD   = 1'b1;
                    end
                end
                ST_WB_AL: begin
                    PCWre     = 1'b1;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = w_is_itype ? 2'b01 : 2'b10;
                end
                ST_WB_LD: begin
                    PCWre     = 1'b1;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b1;
                    RegDst    = 2'b01;
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Brief    : Directed bench for mc_ctrl with an expected-output scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc, RegDst;
    logic       WrRegDSrc, DBDataSrc, ExtSel;
    logic [2:0] state;

    mc_ctrl #(.HALT_OP(6'b111111)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .ExtSel(ExtSel), .state(state)
    );

    always #5 clk = ~clk;

    // {state, PCWre, IRWre, RegWre, mRD, mWR, SrcA, SrcB, ALUOp, PCSrc, RegDst, WrRegDSrc, DBDataSrc, ExtSel}
    logic [19:0] obs;
    assign obs = {state, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB,
                  ALUOp, PCSrc, RegDst, WrRegDSrc, DBDataSrc, ExtSel};

    localparam logic [2:0] IF = 3'b000, ID = 3'b001, EXE_LS = 3'b010, MEM = 3'b011,
                           WB_LD = 3'b100, EXE_BR = 3'b101, EXE_AL = 3'b110, WB_AL = 3'b111;

    logic [19:0] exp_q[$];
    string       tag_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  m_st;
    bit          m_halt;

    function automatic logic [19:0] expect_out(logic [2:0] st, bit hlt, logic [5:0] o, logic z, logic r);
        logic pcw, irw, rw, rd, wr, sa, sb, ext, wrs, dbs;
        logic [2:0] aop;
        logic [1:0] psrc, rdst;
        {pcw, irw, rw, rd, wr, sa, sb, ext, wrs, dbs} = '0;
        aop = 3'b000; psrc = 2'b00; rdst = 2'b00;
        if (!r) begin
            if (st != IF) begin
                case (o)
                    6'b000001, 6'b110100: aop = 3'b001;
                    6'b010001:            aop = 3'b010;
                    6'b010010, 6'b010000: aop = 3'b011;
                    6'b100110:            aop = 3'b100;
                    6'b011000:            aop = 3'b101;
                    default:              aop = 3'b000;
                endcase
                sa  = (o == 6'b011000);
                sb  = (o == 6'b000010) || (o == 6'b010000) || (o == 6'b110000) || (o == 6'b110001);
                ext = (o != 6'b010000);
            end
            case (st)
                IF: irw = 1'b1;
                ID: if (!hlt && (o == 6'b111000 || o == 6'b111010 || o == 6'b111001)) begin
                    pcw  = 1'b1;
                    psrc = (o == 6'b111001) ? 2'b10 : 2'b11;
                    rw   = (o == 6'b111010);
                end
                EXE_BR: begin aop = 3'b001; pcw = 1'b1; psrc = z ? 2'b01 : 2'b00; end
                MEM: begin
                    wr  = (o == 6'b110000);
                    pcw = (o == 6'b110000);
                    rd  = (o == 6'b110001);
                end
                WB_AL: begin
                    pcw = 1'b1; rw = 1'b1; wrs = 1'b1;
                    rdst = (o == 6'b000010 || o == 6'b010000) ? 2'b01 : 2'b10;
                end
                WB_LD: begin pcw = 1'b1; rw = 1'b1; wrs = 1'b1; dbs = 1'b1; rdst = 2'b01; end
                default: ;
            endcase
        end
        return {st, pcw, irw, rw, rd, wr, sa, sb, aop, psrc, rdst, wrs, dbs, ext};
    endfunction

    task automatic model_step(logic r, logic [5:0] o);
        if (r) begin
            m_st = IF; m_halt = 1'b0;
        end else if (!m_halt) begin
            case (m_st)
                IF: m_st = ID;
                ID: begin
                    if (o == 6'b111111) m_halt = 1'b1;
                    else if (o == 6'b111000 || o == 6'b111010 || o == 6'b111001) m_st = IF;
                    else if (o == 6'b110100) m_st = EXE_BR;
                    else if (o == 6'b110000 || o == 6'b110001) m_st = EXE_LS;
                    else m_st = EXE_AL;
                end
                EXE_AL: m_st = WB_AL;
                EXE_LS: m_st = MEM;
                MEM:    m_st = (o == 6'b110001) ? WB_LD : IF;
                default: m_st = IF;
            endcase
        end
    endtask

    // One clock: drive inputs, push the prediction, pop and check at negedge.
    task automatic run_cycle(logic r, logic [5:0] o, logic z, string tag);
        logic [19:0] e;
        string       t;
        rst = r; op = o; zero = z;
        exp_q.push_back(expect_out(m_st, m_halt, o, z, r));
        tag_q.push_back($sformatf("%s/st%0d", tag, m_st));
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_tests++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %05h expected %05h", t, obs, e);
        end
        model_step(r, o);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(logic [5:0] o, logic z, int ncyc, string tag);
        for (int i = 0; i < ncyc; i++) run_cycle(1'b0, o, z, tag);
    endtask

    initial begin
        rst = 1'b1; op = 6'b000000; zero = 1'b0;
        m_st = IF; m_halt = 1'b0;
        @(posedge clk);
        #1;
        run_cycle(1'b1, 6'b000000, 1'b0, "reset");
        run_cycle(1'b1, 6'b110000, 1'b1, "reset_hold");

        run_instr(6'b000000, 1'b0, 4, "add");
        run_instr(6'b110001, 1'b0, 5, "lw");
        run_instr(6'b110100, 1'b1, 3, "beq_taken");
        run_instr(6'b110100, 1'b0, 3, "beq_not");
        run_instr(6'b111010, 1'b0, 2, "jal");
        run_instr(6'b111001, 1'b0, 2, "jr");
        run_instr(6'b111000, 1'b1, 2, "j");
        run_instr(6'b000001, 1'b1, 4, "sub");
        run_instr(6'b010001, 1'b0, 4, "and");
        run_instr(6'b010010, 1'b0, 4, "or");
        run_instr(6'b100110, 1'b0, 4, "slt");
        run_instr(6'b011000, 1'b0, 4, "sll");
        run_instr(6'b000010, 1'b0, 4, "addi");
        run_instr(6'b010000, 1'b0, 4, "ori");
        run_instr(6'b101010, 1'b0, 4, "unknown");
        run_instr(6'b110000, 1'b0, 4, "sw");

        // sw interrupted by reset while in MEM
        run_instr(6'b110000, 1'b0, 3, "sw_pre");
        run_cycle(1'b1, 6'b110000, 1'b0, "sw_rst_mem");
        run_instr(6'b000000, 1'b0, 4, "add_after_rst");

        // HALT parks for 20 cycles, only reset leaves it
        run_instr(6'b111111, 1'b0, 2, "halt_entry");
        run_instr(6'b111111, 1'b1, 20, "halt_park");
        run_cycle(1'b1, 6'b111111, 1'b0, "halt_rst");
        run_instr(6'b000010, 1'b0, 4, "addi_after_halt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
